// File: rtl/timer_seq_pkg.sv
// Shared encodings for the timer sequencer: widths, opcodes, FSM states and
// the instruction-word split helper.
package timer_seq_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_LDI  = 4'h1;
  localparam logic [OP_W-1:0] OP_DEC  = 4'h2;
  localparam logic [OP_W-1:0] OP_INC  = 4'h3;
  localparam logic [OP_W-1:0] OP_JMP  = 4'h4;
  localparam logic [OP_W-1:0] OP_JZ   = 4'h5;
  localparam logic [OP_W-1:0] OP_JM   = 4'h6;
  localparam logic [OP_W-1:0] OP_WAIT = 4'h7;
  localparam logic [OP_W-1:0] OP_OUT  = 4'h8;
  localparam logic [OP_W-1:0] OP_ALM  = 4'h9;
  localparam logic [OP_W-1:0] OP_HALT = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_EXEC      = 3'd2,
    ST_WAIT_TICK = 3'd3,
    ST_HALT      = 3'd4
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] k;
  } instr_t;

  function automatic instr_t split_instr(input logic [OP_W+DATA_W-1:0] word);
    instr_t r;
    r.op = word[OP_W+DATA_W-1:DATA_W];
    r.k  = word[DATA_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/timer_seq_decode.sv
// Combinational instruction decode: next accumulator, PC request and
// next-state selects for one EXEC cycle.
module timer_seq_decode
  import timer_seq_pkg::*;
#(
  parameter int DW = timer_seq_pkg::DATA_W,
  parameter int OW = timer_seq_pkg::OP_W
) (
  input  logic [OW-1:0] op,
  input  logic [DW-1:0] k,
  input  logic [DW-1:0] acc,
  input  logic          mode,
  output logic [DW-1:0] acc_next,
  output logic          req_inc,
  output logic          req_load,
  output logic [DW-1:0] req_load_val,
  output logic          out_en,
  output logic          alm_en,
  output logic          alm_val,
  output logic          go_wait,
  output logic          go_halt,
  output logic          bad_op
);

  localparam logic [DW-1:0] ONE = DW'(1);

  always_comb begin
    acc_next     = acc;
    req_inc      = 1'b0;
    req_load     = 1'b0;
    req_load_val = '0;
    out_en       = 1'b0;
    alm_en       = 1'b0;
    alm_val      = k[0];
    go_wait      = 1'b0;
    go_halt      = 1'b0;
    bad_op       = 1'b0;
    case (op)
      OP_NOP: req_inc = 1'b1;
      OP_LDI: begin
        acc_next = k;
        req_inc  = 1'b1;
      end
      OP_DEC: begin
        acc_next = (acc == '0) ? '0 : acc - ONE;
        req_inc  = 1'b1;
      end
      OP_INC: begin
        acc_next = acc + ONE;
        req_inc  = 1'b1;
      end
      OP_JMP: begin
        req_load     = 1'b1;
        req_load_val = k;
      end
      OP_JZ: begin
        if (acc == '0) begin
          req_load     = 1'b1;
          req_load_val = k;
        end else begin
          req_inc = 1'b1;
        end
      end
      OP_JM: begin
        if (mode) begin
          req_load     = 1'b1;
          req_load_val = k;
        end else begin
          req_inc = 1'b1;
        end
      end
      OP_WAIT: go_wait = 1'b1;
      OP_OUT: begin
        out_en  = 1'b1;
        req_inc = 1'b1;
      end
      OP_ALM: begin
        alm_en  = 1'b1;
        req_inc = 1'b1;
      end
      OP_HALT: go_halt = 1'b1;
      default: begin
        // Undefined opcodes execute as NOP but leave a sticky trace.
        bad_op  = 1'b1;
        req_inc = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/timer_sequencer.sv
// Fetch/execute controller for the timer ISA; drives the external PC and
// reads its ROM one cycle after the PC value is presented.
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_IDLE      | stopped, waiting for start; no PC requests
// ST_FETCH     | ROM read of the word at pc_value in flight
// ST_EXEC      | decode rom_data, issue pc_inc/pc_load for this edge
// ST_WAIT_TICK | parked on a WAIT; next tick advances the PC
// ST_HALT      | parked on a HALT; start advances the PC, alarm held
module timer_sequencer
  import timer_seq_pkg::*;
#(
  parameter int DATA_W = timer_seq_pkg::DATA_W,
  parameter int OP_W   = timer_seq_pkg::OP_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      pc_value,
  input  logic [OP_W+DATA_W-1:0] rom_data,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   tick,
  input  logic                   mode,
  output logic                   pc_inc,
  output logic                   pc_load,
  output logic [DATA_W-1:0]      pc_load_val,
  output logic                   pc_reset,
  output logic [DATA_W-1:0]      count_out,
  output logic                   count_valid,
  output logic                   alarm,
  output logic                   illegal
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              count_valid_q, count_valid_d;
  logic              alarm_q, alarm_d;
  logic              illegal_q, illegal_d;
  logic              pc_reset_q, pc_reset_d;

  instr_t            instr;
  logic [DATA_W-1:0] dec_acc;
  logic              dec_inc, dec_load;
  logic [DATA_W-1:0] dec_load_val;
  logic              dec_out, dec_alm, dec_alm_val;
  logic              dec_wait, dec_halt, dec_bad;

  assign instr = split_instr(rom_data);

  timer_seq_decode #(
    .DW (DATA_W),
    .OW (OP_W)
  ) u_decode (
    .op           (instr.op),
    .k            (instr.k),
    .acc          (acc_q),
    .mode         (mode),
    .acc_next     (dec_acc),
    .req_inc      (dec_inc),
    .req_load     (dec_load),
    .req_load_val (dec_load_val),
    .out_en       (dec_out),
    .alm_en       (dec_alm),
    .alm_val      (dec_alm_val),
    .go_wait      (dec_wait),
    .go_halt      (dec_halt),
    .bad_op       (dec_bad)
  );

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    count_d       = count_q;
    count_valid_d = 1'b0;
    alarm_d       = alarm_q;
    illegal_d     = illegal_q;
    pc_reset_d    = 1'b0;
    pc_inc        = 1'b0;
    pc_load       = 1'b0;
    pc_load_val   = '0;

    // stop overrides everything else once the sequencer is running.
    if (stop && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      pc_reset_d = 1'b1;
      alarm_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) state_d = ST_FETCH;
        end
        ST_FETCH: state_d = ST_EXEC;
        ST_EXEC: begin
          acc_d       = dec_acc;
          pc_inc      = dec_inc;
          pc_load     = dec_load;
          pc_load_val = dec_load_val;
          if (dec_out) begin
            count_d       = acc_q;
            count_valid_d = 1'b1;
          end
          if (dec_alm) alarm_d = dec_alm_val;
          if (dec_bad) illegal_d = 1'b1;
          if (dec_wait)      state_d = ST_WAIT_TICK;
          else if (dec_halt) state_d = ST_HALT;
          else               state_d = ST_FETCH;
        end
        ST_WAIT_TICK: begin
          if (tick) begin
            pc_inc  = 1'b1;
            state_d = ST_FETCH;
          end
        end
        ST_HALT: begin
          if (start) begin
            pc_inc  = 1'b1;
            state_d = ST_FETCH;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      acc_q         <= '0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
      alarm_q       <= 1'b0;
      illegal_q     <= 1'b0;
      pc_reset_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      count_q       <= count_d;
      count_valid_q <= count_valid_d;
      alarm_q       <= alarm_d;
      illegal_q     <= illegal_d;
      pc_reset_q    <= pc_reset_d;
    end
  end

  assign count_out   = count_q;
  assign count_valid = count_valid_q;
  assign alarm       = alarm_q;
  assign illegal     = illegal_q;
  assign pc_reset    = pc_reset_q;

  // pc_value only addresses the ROM externally; the sequencer never needs it.
  logic unused_pc;
  assign unused_pc = ^pc_value;

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer with a PC + synchronous ROM model around it;
// displayed counts and PC loads are scoreboarded.
module tb_timer_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pc_value;
  logic [11:0] rom_data;
  logic        start, stop, tick, mode;
  logic        pc_inc, pc_load, pc_reset;
  logic [7:0]  pc_load_val, count_out;
  logic        count_valid, alarm, illegal;

  logic [11:0] rom [256];
  logic [7:0]  pc_q;

  int checks = 0;
  int errors = 0;
  int inc_cnt = 0;
  logic [7:0] exp_count[$];
  logic [7:0] exp_load[$];

  always #5 clk = ~clk;

  timer_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .pc_value    (pc_value),
    .rom_data    (rom_data),
    .start       (start),
    .stop        (stop),
    .tick        (tick),
    .mode        (mode),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .pc_reset    (pc_reset),
    .count_out   (count_out),
    .count_valid (count_valid),
    .alarm       (alarm),
    .illegal     (illegal)
  );

  always @(posedge clk or negedge reset) begin
    if (!reset)        pc_q <= 8'h00;
    else if (pc_reset) pc_q <= 8'h00;
    else if (pc_load)  pc_q <= pc_load_val;
    else if (pc_inc)   pc_q <= pc_q + 8'h01;
  end
  assign pc_value = pc_q;

  always @(posedge clk) rom_data <= rom[pc_q];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 12'hA00;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic go_idle();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("stop_pc_reset_hi", pc_reset, 1);
    chk("stop_alarm_clr", alarm, 0);
    cyc(1);
    chk("stop_pc_reset_lo", pc_reset, 0);
    chk("stop_pc_zero", pc_q, 0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (reset) begin
      chk("pc_req_excl", {23'd0, pc_inc & pc_load, (pc_load ? 8'h00 : pc_load_val)}, 0);
      if (pc_inc) inc_cnt++;
      if (count_valid) begin
        if (exp_count.size() == 0) chk("count_unexpected", {24'd0, count_out}, 32'hFFFF_FFFF);
        else chk("count_out", count_out, exp_count.pop_front());
      end
      if (pc_load) begin
        if (exp_load.size() == 0) chk("load_unexpected", {24'd0, pc_load_val}, 32'hFFFF_FFFF);
        else chk("pc_load_val", pc_load_val, exp_load.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    reset = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0; mode = 1'b0;
    clear_rom();
    rom[0] = 12'h105;
    rom[1] = 12'h800;
    #12;
    chk("rst_outputs", {pc_inc, pc_load, pc_load_val, pc_reset, count_out, count_valid, alarm, illegal}, 0);
    #11 reset = 1'b1;
    cyc(2);

    // Reset asserted in the middle of an EXEC cycle.
    pulse_start();
    cyc(1);
    chk("exec_inc_before_rst", pc_inc, 1);
    #2 reset = 1'b0;
    #1;
    chk("midexec_rst_outputs", {pc_inc, pc_load, pc_load_val, pc_reset, count_out, count_valid, alarm, illegal}, 0);
    #2 reset = 1'b1;
    cyc(1);
    snap = inc_cnt;
    cyc(5);
    chk("idle_no_inc", inc_cnt, snap);
    chk("idle_pc", pc_q, 0);

    // LDI 5 / OUT: strobe lands four edges after the start edge.
    exp_count.push_back(8'd5);
    pulse_start();
    cyc(3);
    chk("ldi_out_no_early_valid", count_valid, 0);
    cyc(1);
    chk("ldi_out_valid", count_valid, 1);
    chk("ldi_out_value", count_out, 5);
    cyc(1);
    chk("ldi_out_valid_1cyc", count_valid, 0);
    cyc(4);
    go_idle();

    // Countdown firmware.
    clear_rom();
    rom[0]  = 12'h603;
    rom[1]  = 12'hA00;
    rom[3]  = 12'h103;
    rom[4]  = 12'h700;
    rom[5]  = 12'h200;
    rom[6]  = 12'h800;
    rom[7]  = 12'h509;
    rom[8]  = 12'h404;
    rom[9]  = 12'h901;
    rom[10] = 12'hA00;
    rom[11] = 12'hA00;
    mode = 1'b1;
    exp_count.push_back(8'd2); exp_count.push_back(8'd1); exp_count.push_back(8'd0);
    exp_load.push_back(8'd3); exp_load.push_back(8'd4); exp_load.push_back(8'd4); exp_load.push_back(8'd9);
    pulse_start();
    cyc(20);
    chk("waiting_pc", pc_q, 4);
    for (int t = 0; t < 3; t++) begin
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      cyc(19);
    end
    chk("cd_alarm", alarm, 1);
    chk("cd_halt_pc", pc_q, 10);
    snap = inc_cnt;
    cyc(5);
    chk("halt_no_inc", inc_cnt, snap);
    chk("halt_pc_held", pc_q, 10);
    chk("halt_count_left", exp_count.size(), 0);
    start = 1'b1;
    @(negedge clk);
    chk("halt_start_inc", pc_inc, 1);
    @(posedge clk); #1;
    start = 1'b0;
    cyc(6);
    chk("halt_resume_pc", pc_q, 11);
    chk("halt_alarm_held", alarm, 1);
    go_idle();
    mode = 1'b0;

    // tick and stop together in WAIT_TICK.
    clear_rom();
    rom[0] = 12'h901;
    rom[1] = 12'h700;
    pulse_start();
    cyc(10);
    chk("wt_alarm_set", alarm, 1);
    chk("wt_pc", pc_q, 1);
    tick = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    chk("tickstop_no_inc", pc_inc, 0);
    @(posedge clk); #1;
    tick = 1'b0;
    stop = 1'b0;
    chk("tickstop_pc_reset", pc_reset, 1);
    chk("tickstop_alarm", alarm, 0);
    cyc(1);
    chk("tickstop_pc_reset_lo", pc_reset, 0);
    snap = inc_cnt;
    tick = 1'b1;
    cyc(3);
    tick = 1'b0;
    chk("tickstop_idle", inc_cnt, snap);
    chk("tickstop_pc", pc_q, 0);

    // DEC saturation, INC wrap, JZ taken.
    clear_rom();
    rom[0]     = 12'h100;
    rom[1]     = 12'h200;
    rom[2]     = 12'h800;
    rom[3]     = 12'h1FF;
    rom[4]     = 12'h300;
    rom[5]     = 12'h800;
    rom[6]     = 12'h540;
    rom[8'h40] = 12'h800;
    exp_count.push_back(8'd0); exp_count.push_back(8'd0); exp_count.push_back(8'd0);
    exp_load.push_back(8'h40);
    pulse_start();
    cyc(30);
    chk("edge_pc", pc_q, 8'h41);
    chk("edge_count_left", exp_count.size(), 0);
    chk("edge_load_left", exp_load.size(), 0);
    go_idle();

    // Undefined opcode 0xC.
    clear_rom();
    rom[0] = 12'hC00;
    rom[1] = 12'h107;
    rom[2] = 12'h800;
    exp_count.push_back(8'd7);
    chk("illegal_clear", illegal, 0);
    pulse_start();
    cyc(1);
    chk("illegal_inc", pc_inc, 1);
    cyc(1);
    chk("illegal_set", illegal, 1);
    cyc(10);
    chk("illegal_sticky", illegal, 1);
    chk("illegal_pc", pc_q, 3);
    go_idle();
    chk("illegal_after_stop", illegal, 1);
    reset = 1'b0;
    #3;
    chk("illegal_reset", illegal, 0);
    reset = 1'b1;
    cyc(2);

    chk("final_count_q", exp_count.size(), 0);
    chk("final_load_q", exp_load.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
